// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port definitions: MemStrobe encodings, arbiter states and the NOP
// returned on a timed-out fetch. main_decoder uses the same strobe constants.
package mem_port_arbiter_pkg;

    localparam logic [1:0]  STRB_BYTE = 2'b01;
    localparam logic [1:0]  STRB_HALF = 2'b10;
    localparam logic [1:0]  STRB_WORD = 2'b11;

    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IF,
        WAIT_D,
        RESP_IF,
        RESP_D
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the unified memory port.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [1:0]  d_strobe;
    logic        d_unsigned;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_strobe, d_unsigned, d_wdata,
               mem_rdata, mem_ready,
        output if_done, if_rdata, d_done, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_strobe, d_unsigned, d_wdata,
               mem_rdata, mem_ready,
        input  if_done, if_rdata, d_done, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational byte-lane steering: byte enables, replicated store data,
// extended load data and misalignment detection from MemStrobe and addr[1:0].
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  strobe,
    input  logic [1:0]  addr,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_aligned,
    output logic [31:0] rdata_extended,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be             = '1;
        wdata_aligned  = wdata;
        rdata_extended = rdata;
        misaligned     = 1'b0;
        byte_sel       = rdata[{addr, 3'b000} +: 8];
        half_sel       = addr[1] ? rdata[31:16] : rdata[15:0];
        case (strobe)
            STRB_BYTE: begin
                be             = 4'b0001 << addr;
                wdata_aligned  = {4{wdata[7:0]}};
                rdata_extended = {{24{~uns & byte_sel[7]}}, byte_sel};
            end
            STRB_HALF: begin
                be             = addr[1] ? 4'b1100 : 4'b0011;
                wdata_aligned  = {2{wdata[15:0]}};
                rdata_extended = {{16{~uns & half_sel[15]}}, half_sel};
                misaligned     = addr[0];
            end
            // STRB_WORD and the unused 2'b00 encoding both mean a full word
            default: misaligned = (addr != 2'b00);
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and data requesters and
// sequences each access over the req/ready handshake with an optional timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter bit          RR_FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0] TO_LIM = TIMEOUT[CW:0];

    arb_state_t    state, state_n;
    grant_t        last_grant;
    logic [CW-1:0] wait_cnt;
    logic [CW:0]   cnt_next;
    logic          pick_d;
    logic          timeout_hit;

    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;
    logic          al_misaligned;

    // Requesters hold their inputs until done, so the live data-side inputs
    // still describe the access when the read word comes back.
    mem_lane_align u_align (
        .strobe         (bus.d_strobe),
        .addr           (bus.d_addr[1:0]),
        .uns            (bus.d_unsigned),
        .wdata          (bus.d_wdata),
        .rdata          (bus.mem_rdata),
        .be             (al_be),
        .wdata_aligned  (al_wdata),
        .rdata_extended (al_rdata),
        .misaligned     (al_misaligned)
    );

    assign pick_d      = bus.d_req && (!bus.if_req || !RR_FAIR || last_grant == GRANT_IF);
    assign cnt_next    = {1'b0, wait_cnt} + {{CW{1'b0}}, 1'b1};
    assign timeout_hit = (TIMEOUT != 0) && (cnt_next == TO_LIM);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (pick_d)          state_n = al_misaligned ? RESP_D : WAIT_D;
                else if (bus.if_req) state_n = WAIT_IF;
            end
            WAIT_IF: if (bus.mem_ready || timeout_hit) state_n = RESP_IF;
            WAIT_D:  if (bus.mem_ready || timeout_hit) state_n = RESP_D;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant    <= GRANT_IF;
            wait_cnt      <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            bus.if_done   <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_done    <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_err     <= 1'b0;
        end else begin
            bus.if_done <= 1'b0;
            bus.d_done  <= 1'b0;
            bus.d_err   <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (pick_d) begin
                        last_grant <= GRANT_D;
                        if (al_misaligned) begin
                            bus.d_done <= 1'b1;
                            bus.d_err  <= 1'b1;
                        end else begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr & 32'hFFFF_FFFC;
                            bus.mem_be    <= al_be;
                            bus.mem_wdata <= al_wdata;
                        end
                    end else if (bus.if_req) begin
                        last_grant    <= GRANT_IF;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr & 32'hFFFF_FFFC;
                        bus.mem_be    <= '1;
                        bus.mem_wdata <= '0;
                    end
                end
                WAIT_IF: begin
                    if (bus.mem_ready || timeout_hit) begin
                        bus.if_rdata <= bus.mem_ready ? bus.mem_rdata : NOP_INSN;
                        bus.mem_req  <= 1'b0;
                        bus.if_done  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_D: begin
                    if (bus.mem_ready) begin
                        bus.d_rdata <= bus.mem_we ? '0 : al_rdata;
                        bus.mem_req <= 1'b0;
                        bus.d_done  <= 1'b1;
                    end else if (timeout_hit) begin
                        bus.mem_req <= 1'b0;
                        bus.d_done  <= 1'b1;
                        bus.d_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requesters push expected results from a byte-level memory
// model; a monitor checks every memory access and every done pulse.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } dresp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(4), .RR_FAIR(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mreq_t       exp_mif[$];
    mreq_t       exp_md[$];
    logic [31:0] exp_if[$];
    dresp_t      exp_d[$];
    bit          glog[$];

    logic [7:0]  mbytes [0:511];
    logic [31:0] pmem   [0:127];

    int n_cmp = 0;
    int n_fail = 0;
    bit stuck = 1'b0;
    bit force_ready = 1'b0;
    bit fair_on = 1'b0;
    int fix_lat = 0;
    int req_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int b;
        b = int'(a[8:2]) * 4;
        return {mbytes[b+3], mbytes[b+2], mbytes[b+1], mbytes[b]};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        int b;
        b = int'(a[8:2]) * 4;
        pmem[a[8:2]] = v;
        for (int k = 0; k < 4; k++) mbytes[b+k] = v[8*k +: 8];
    endtask

    task automatic do_fetch(input logic [31:0] a, input int exp_lat, input bit keep);
        mreq_t m;
        int    lat;
        bit    got;
        m.addr  = {a[31:2], 2'b00};
        m.be    = 4'hF;
        m.we    = 1'b0;
        m.wdata = 32'h0;
        exp_mif.push_back(m);
        exp_if.push_back(stuck ? NOP_INSN : model_word(a));
        @(posedge clk); #1;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.if_done) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        if (!got) fail_evt("if_done_wait_expired");
        else if (exp_lat >= 0) check("if_latency", 32'(lat), 32'(exp_lat));
        if (!keep) begin
            @(posedge clk); #1;
            bus.if_req = 1'b0;
        end
    endtask

    task automatic do_data(input logic we, input logic [1:0] strb, input logic [31:0] a,
                           input logic uns, input logic [31:0] wd, input int exp_lat,
                           input bit keep);
        int          size, off, ai, lat;
        bit          mis, err, got;
        logic [31:0] val;
        mreq_t       m;
        dresp_t      r;
        size = (strb == 2'b01) ? 1 : (strb == 2'b10) ? 2 : 4;
        off  = int'(a[1:0]);
        ai   = int'(a[8:0]);
        mis  = (off % size) != 0;
        err  = mis || stuck;
        if (!mis) begin
            m.addr  = {a[31:2], 2'b00};
            m.be    = 4'((1 << size) - 1) << off;
            m.we    = we;
            m.wdata = (size == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
                      (size == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
            exp_md.push_back(m);
        end
        val = 32'h0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++) mbytes[ai+k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < size; k++) val = val | (32'(mbytes[ai+k]) << (8*k));
                if (!uns && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
            end
        end
        r.err   = err;
        r.rdata = val;
        exp_d.push_back(r);
        @(posedge clk); #1;
        bus.d_req      = 1'b1;
        bus.d_we       = we;
        bus.d_addr     = a;
        bus.d_strobe   = strb;
        bus.d_unsigned = uns;
        bus.d_wdata    = wd;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.d_done) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        if (!got) fail_evt("d_done_wait_expired");
        else if (exp_lat >= 0) check("d_latency", 32'(lat), 32'(exp_lat));
        if (!keep) begin
            @(posedge clk); #1;
            bus.d_req = 1'b0;
        end
    endtask

    // Memory responder: ready after a programmable number of wait cycles
    initial begin
        bit active;
        int waitn;
        logic [6:0] w;
        active = 1'b0;
        waitn = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            if (force_ready) begin
                active = 1'b0;
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end else if (rst || !bus.mem_req) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    active  = 1'b1;
                    req_len = 0;
                    waitn   = stuck ? 1_000_000 : (fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 3)));
                end
                req_len++;
                if (waitn == 0) begin
                    w = bus.mem_addr[8:2];
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = pmem[w];
                    if (bus.mem_we)
                        for (int b = 0; b < 4; b++)
                            if (bus.mem_be[b]) pmem[w][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                    active = 1'b0;
                end else begin
                    waitn--;
                end
            end
        end
    end

    // Monitor: memory-side requests and done pulses against the scoreboard
    initial begin
        bit prev_req, prev_ifd, prev_dd;
        mreq_t m;
        dresp_t r;
        logic [31:0] e;
        prev_req = 1'b0;
        prev_ifd = 1'b0;
        prev_dd  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.if_done) begin
                if (prev_ifd) fail_evt("if_done_longer_than_one_cycle");
                if (exp_if.size() == 0) fail_evt("if_done_without_request");
                else begin
                    e = exp_if.pop_front();
                    check("if_rdata", bus.if_rdata, e);
                end
            end
            if (bus.d_done) begin
                if (prev_dd) fail_evt("d_done_longer_than_one_cycle");
                if (exp_d.size() == 0) fail_evt("d_done_without_request");
                else begin
                    r = exp_d.pop_front();
                    check("d_err", 32'(bus.d_err), 32'(r.err));
                    if (!r.err) check("d_rdata", bus.d_rdata, r.rdata);
                end
            end
            if (bus.mem_req && !prev_req) begin
                if (bus.mem_addr < 32'h100) begin
                    if (fair_on) glog.push_back(1'b0);
                    if (exp_mif.size() == 0) begin
                        fail_evt("fetch_access_without_request");
                        m = '{32'h0, 4'h0, 1'b0, 32'h0};
                    end else m = exp_mif.pop_front();
                end else begin
                    if (fair_on) glog.push_back(1'b1);
                    if (exp_md.size() == 0) begin
                        fail_evt("data_access_without_request");
                        m = '{32'h0, 4'h0, 1'b0, 32'h0};
                    end else m = exp_md.pop_front();
                end
                check("mem_addr", bus.mem_addr, m.addr);
                check("mem_be", 32'(bus.mem_be), 32'(m.be));
                check("mem_we", 32'(bus.mem_we), 32'(m.we));
                if (m.we) check("mem_wdata", bus.mem_wdata, m.wdata);
            end
            prev_req = bus.mem_req;
            prev_ifd = bus.if_done;
            prev_dd  = bus.d_done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h0;
        bus.d_strobe = 2'b00;
        bus.d_unsigned = 1'b0;
        bus.d_wdata = 32'h0;
        for (int i = 0; i < 128; i++) set_word(32'(i * 4), $urandom());

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_be", 32'(bus.mem_be), 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_if_done", 32'(bus.if_done), 32'h0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_d_done", 32'(bus.d_done), 32'h0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        check("rst_d_err", 32'(bus.d_err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed: zero-wait fetch, sub-word loads/stores, misalignment
        fix_lat = 0;
        set_word(32'h40, 32'h0050_0093);
        do_fetch(32'h40, 2, 1'b0);
        check("fetch_req_cycles", 32'(req_len), 32'd1);
        set_word(32'h100, 32'h8001_1234);
        do_data(1'b0, STRB_HALF, 32'h102, 1'b0, 32'h0, 2, 1'b0);
        do_data(1'b0, STRB_HALF, 32'h102, 1'b1, 32'h0, 2, 1'b0);
        do_data(1'b1, STRB_BYTE, 32'h103, 1'b0, 32'h0000_00AB, 2, 1'b0);
        do_data(1'b0, STRB_WORD, 32'h100, 1'b0, 32'h0, 2, 1'b0);
        fix_lat = 1;
        do_data(1'b0, STRB_BYTE, 32'h101, 1'b0, 32'h0, 3, 1'b0);
        do_data(1'b1, STRB_HALF, 32'h10A, 1'b0, 32'h1234_5678, 3, 1'b0);
        do_data(1'b0, 2'b00, 32'h108, 1'b0, 32'h0, 3, 1'b0);
        do_data(1'b0, STRB_WORD, 32'h006, 1'b0, 32'h0, 1, 1'b0);
        do_data(1'b1, STRB_HALF, 32'h105, 1'b0, 32'hFFFF, 1, 1'b0);

        // Timeout with memory never ready
        @(negedge clk);
        stuck = 1'b1;
        do_data(1'b0, STRB_WORD, 32'h104, 1'b0, 32'h0, 5, 1'b0);
        check("timeout_req_cycles", 32'(req_len), 32'd4);
        do_fetch(32'h44, 5, 1'b0);

        // Reset during WAIT_D, then a late mem_ready
        exp_md.push_back('{32'h108, 4'hF, 1'b0, 32'h0});
        @(posedge clk); #1;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h108;
        bus.d_strobe = STRB_WORD;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_mem_req", 32'(bus.mem_req), 32'h1);
        rst = 1'b1;
        bus.d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_abort_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_abort_d_done", 32'(bus.d_done), 32'h0);
        stuck = 1'b0;
        force_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ready_mem_req", 32'(bus.mem_req), 32'h0);
            check("late_ready_d_done", 32'(bus.d_done), 32'h0);
        end
        force_ready = 1'b0;
        fix_lat = 0;
        do_fetch(32'h48, 2, 1'b0);

        // Randomised concurrent traffic with random memory latency
        fix_lat = -1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    do_fetch(32'($urandom_range(0, 63)) * 4, -1, 1'b0);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    do_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            32'h100 + 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                            $urandom(), -1, 1'b0);
                end
            end
        join

        // Both requesters continuously pending: grants must alternate
        fix_lat = 2;
        glog.delete();
        fair_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) do_fetch(32'(i * 4), -1, i < 5);
            end
            begin
                for (int i = 0; i < 6; i++) do_data(1'b0, STRB_WORD, 32'h180 + 32'(i * 4), 1'b0, 32'h0, -1, i < 5);
            end
        join
        fair_on = 1'b0;
        check("fair_grant_count", 32'(glog.size()), 32'd12);
        for (int i = 1; i < glog.size(); i++)
            check("fair_alternation", 32'(glog[i]), 32'(!glog[i-1]));

        repeat (4) @(posedge clk);
        check("exp_if_drained", 32'(exp_if.size()), 32'd0);
        check("exp_d_drained", 32'(exp_d.size()), 32'd0);
        check("exp_mem_drained", 32'(exp_mif.size() + exp_md.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port of the pipelined RV32I core between the fetch stage (instruction reads) and the memory stage (loads and stores).
Arbitrates between the two requesters and sequences each access over a variable-latency req/ready memory handshake.
Converts the main decoder's MemStrobe encoding (01 byte, 10 half, 11 word) into byte enables, lane-shifted write data and sign/zero-extended load data.
Reports misaligned and timed-out accesses; its done outputs drive stall_F and stall_M in the hazard unit.

Parameters:
TIMEOUT, 255, cycles to wait for mem_ready before aborting; 0 disables the timeout
RR_FAIR, 1, 1 = alternate grants when both requesters are pending; 0 = data always wins

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high until if_done
if_addr  in  32  fetch byte address (word aligned)
if_done  out  1  one-cycle pulse: if_rdata is valid
if_rdata  out  32  fetched instruction, registered
d_req  in  1  data request; held high until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_strobe  in  2  MemStrobe: 01 byte, 10 half, 11 word; 00 is treated as word
d_unsigned  in  1  funct3[2]; 1 = zero-extend loads (LBU/LHU)
d_wdata  in  32  store data, right-justified
d_done  out  1  one-cycle pulse: access finished
d_rdata  out  32  extended load data, registered
d_err  out  1  valid with d_done: misaligned access or timeout
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  32  {addr[31:2], 2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-aligned store data
mem_rdata  in  32  read word, valid when mem_ready=1
mem_ready  in  1  access complete; may be high in the first cycle mem_req is high

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=fetch, timeout counter 0. Reset mid-access drops mem_req in the next cycle and abandons the access; no done pulse is produced.
- FSM states: IDLE, WAIT_IF, WAIT_D, RESP_IF, RESP_D.
- IDLE, no requests: stay in IDLE.
- IDLE, only one requester pending: grant it.
- IDLE, both requesters pending:
  - RR_FAIR=1: grant the requester that is not last_grant.
  - RR_FAIR=0: grant data.
- On grant: register mem_addr, mem_be, mem_we, mem_wdata; set mem_req=1; go to WAIT_x; update last_grant.
- Fetch accesses always use mem_we=0 and mem_be=1111.
- Misaligned data access: half with addr[0]=1, or word with addr[1:0]!=0.
  - No memory access is issued; go straight to RESP_D with d_err=1.
  - d_done is high in cycle t+1 after the sampled request.
- WAIT_x, mem_ready=1:
  - Capture mem_rdata (fetch) or the extended load data (data).
  - Drop mem_req.
  - Go to RESP_x.
- WAIT_x, mem_ready=0: increment the counter. When the counter reaches TIMEOUT (TIMEOUT != 0):
  - Drop mem_req and go to RESP_x.
  - RESP_D: d_err=1.
  - RESP_IF: if_rdata=32'h00000013 (NOP).
- RESP_x: pulse x_done for exactly one cycle, then go to IDLE. No new arbitration happens in RESP_x, so a request still held in the done cycle is not re-issued.
- mem_ready while in IDLE or RESP is ignored.
- Zero-wait memory timing: req sampled at t, mem_req high at t+1, done at t+2, next grant at t+3.
- Byte access:
  - mem_be = 0001 << addr[1:0].
  - mem_wdata = {4{wdata[7:0]}}.
  - Load takes rdata byte addr[1:0], then sign- or zero-extends it.
- Half access:
  - mem_be = addr[1] ? 1100 : 0011.
  - mem_wdata = {2{wdata[15:0]}}.
  - Load takes the selected half, then sign- or zero-extends it.
- Word access: mem_be=1111, data passed through unchanged.
- Stores: d_rdata=0. d_rdata and if_rdata hold their values until the next capture.

Decomposition:
- Shared package holds:
  - MemStrobe constants STRB_BYTE=2'b01, STRB_HALF=2'b10, STRB_WORD=2'b11.
  - State encoding.
  - NOP constant 32'h00000013.
  - These constants are also used by main_decoder.
- One sub-module, mem_lane_align, is combinational:
  - Inputs: strobe, addr[1:0], unsigned, wdata, rdata.
  - Outputs: be, wdata_aligned, rdata_extended, misaligned.

Test Plan:
- Fetch only, 0x0000_0040, ready on the first wait cycle with rdata=0x00500093 -> mem_be=1111, mem_req high for 1 cycle, if_done at t+2, if_rdata=0x00500093.
- SB at 0x103, wdata=0x000000AB -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x100, d_done with d_err=0.
- LH at 0x102 with rdata=0x8001_1234 -> d_rdata=0xFFFF8001; same access as LHU -> 0x00008001.
- Both requests held continuously, RR_FAIR=1, 2 ready-wait cycles -> grants alternate D, IF, D, IF; neither requester waits more than one other grant.
- LW at 0x006 -> no mem_req, d_done at t+1 with d_err=1. Separately, TIMEOUT=4 with mem_ready stuck low -> mem_req drops after 4 wait cycles and d_done/d_err pulse.
- rst asserted during WAIT_D -> mem_req=0 the next cycle, no d_done, state IDLE; a late mem_ready is ignored.
